// File: rtl/serial_subtractor_pkg.sv
// Shared state encoding for the bit-serial arithmetic blocks (adder and subtractor).
package serial_subtractor_pkg;
  typedef enum logic [1:0] {
    SA_IDLE  = 2'd0,
    SA_SHIFT = 2'd1,
    SA_FIN   = 2'd2
  } sa_state_e;
endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/serial_subtractor_fsm.sv
// Sequencer for the serial subtractor: IDLE -> SHIFT (SIZE edges) -> FIN -> IDLE.
module serial_subtractor_fsm
  import serial_subtractor_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_load,
  output logic o_shift,
  output logic o_last,
  output logic o_busy
);
  localparam int COUNT_W = $clog2(SIZE + 1);
  localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(SIZE - 1);

  sa_state_e          CURRENT_STATE, w_next;
  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      CURRENT_STATE <= SA_IDLE;
      r_count       <= '0;
    end else begin
      CURRENT_STATE <= w_next;
      if (o_load)       r_count <= '0;
      else if (o_shift) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_next  = CURRENT_STATE;
    o_load  = 1'b0;
    o_shift = 1'b0;
    o_last  = 1'b0;
    unique case (CURRENT_STATE)
      SA_IDLE: if (i_start) begin
        o_load = 1'b1;
        w_next = SA_SHIFT;
      end
      SA_SHIFT: begin
        o_shift = 1'b1;
        if (r_count == LAST_CNT) begin
          o_last = 1'b1;
          w_next = SA_FIN;
        end
      end
      SA_FIN:  w_next = SA_IDLE;
      default: w_next = SA_IDLE;
    endcase
  end

  assign o_busy = (CURRENT_STATE == SA_SHIFT);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A-B LSB-first through a borrow flop, SIZE+1-bit result.
// Optional SUB_FLAGS_EN adds registered ZERO/NEG flags alongside DIFF.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  output logic [SIZE:0]   DIFF,
  output logic          BUSY,
  output logic          DONE
`ifdef SUB_FLAGS_EN
  ,
  output logic          ZERO,
  output logic          NEG
`endif
);
  logic [SIZE-1:0] r_sa, r_sb, r_res;
  logic            r_br, r_done;
  logic [SIZE:0]   r_diff;
  logic            w_load, w_shift, w_last, w_busy;
  logic            w_d, w_bout;
  logic [SIZE:0]   w_result;

  serial_subtractor_fsm #(.SIZE(SIZE)) FSM_1 (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_start (START),
    .o_load  (w_load),
    .o_shift (w_shift),
    .o_last  (w_last),
    .o_busy  (w_busy)
  );

  full_subtractor_cell FS_1 (
    .i_a    (r_sa[0]),
    .i_b    (r_sb[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // Final borrow becomes the sign bit; the last difference bit lands just below it.
  assign w_result = {w_bout, w_d, r_res[SIZE-1:1]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_diff <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_sa <= A;
        r_sb <= B;
        r_br <= 1'b0;
      end else if (w_shift) begin
        r_sa  <= {1'b0, r_sa[SIZE-1:1]};
        r_sb  <= {1'b0, r_sb[SIZE-1:1]};
        r_res <= {w_d, r_res[SIZE-1:1]};
        r_br  <= w_bout;
      end
      if (w_last) r_diff <= w_result;
    end
  end

`ifdef SUB_FLAGS_EN
  logic r_zero, r_neg;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_last) begin
      r_zero <= (w_result == '0);
      r_neg  <= w_bout;
    end
  end
  assign ZERO = r_zero;
  assign NEG  = r_neg;
`endif

  assign DIFF = r_diff;
  assign BUSY = w_busy;
  assign DONE = r_done;
endmodule
